xmit_priority_scheduler: RTL
============================

Name: xmit_priority_scheduler

Overview:
Frame-level arbiter for the transmit path. Sits between the hi- and lo-priority receive control queues and the PHY transmit engine. Selects the next frame using strict priority with a starvation guard and validates frame length, discarding out-of-range frames. Sequences the transmitter with start/done handshakes, enforces an inter-frame gap, and aborts hung frames on timeout.

Parameters:
LEN_W, 12, width of frame length field (byte count, from 12-bit ctrl-block length field)
MIN_LEN, 1, smallest legal length; shorter frames are discarded
MAX_LEN, 1518, largest legal length; longer frames are discarded
HI_BURST, 4, max consecutive hi grants while a lo frame waits
IFG_CYCLES, 12, idle clk_sys cycles after each frame before next grant
TIMEOUT, 4096, BUSY cycles before abort (timeout counter 16 bits)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
hi_frame_avail  in  1  hi queue holds a complete frame
hi_frame_len  in  LEN_W  length of hi head frame
lo_frame_avail  in  1  lo queue holds a complete frame
lo_frame_len  in  LEN_W  length of lo head frame
tx_ready  in  1  transmit engine idle, can accept start
tx_done  in  1  one-cycle pulse, frame fully sent
hi_pop  out  1  one-cycle dequeue pulse to hi queue
lo_pop  out  1  one-cycle dequeue pulse to lo queue
tx_start  out  1  one-cycle start pulse to transmitter
tx_sel_hi  out  1  datapath select, 1=hi queue; held from GRANT to end of BUSY
tx_len  out  LEN_W  latched length of granted frame
tx_abort  out  1  one-cycle pulse on timeout
discard_en  out  1  one-cycle pulse, head frame dropped
discard_hi  out  1  queue of discarded frame, valid with discard_en
busy  out  1  high in GRANT, BUSY, IFG

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0; tx_len 0; streak and counters 0. Reset mid-frame abandons it; no start reissued after release.
- All outputs registered. States: IDLE, GRANT, DISCARD, BUSY, IFG.
- IDLE: arbitrate each cycle only if tx_ready=1 and at least one avail.
  - pick_hi = hi_avail & ~(lo_avail & streak==HI_BURST); pick_lo = lo_avail & ~pick_hi.
  - Selected len < MIN_LEN or > MAX_LEN -> DISCARD, else -> GRANT.
  - Neither avail or tx_ready=0 -> stay IDLE.
- GRANT (1 cycle): tx_start=1, pop of selected queue=1, tx_len/tx_sel_hi loaded. Latency: avail sampled at edge N -> tx_start/pop high in cycle N+1. Streak update: lo grant -> 0; hi grant with lo_avail=1 -> min(streak+1, HI_BURST); hi grant with lo_avail=0 -> 0. Next: BUSY, timeout counter cleared.
- DISCARD (1 cycle): discard_en=1, discard_hi=selection, pop of that queue=1; no tx_start; streak unchanged; next IDLE. The next IDLE cycle sees post-pop avail/len.
- BUSY: timeout counter increments each cycle. tx_done=1 -> IFG. Counter reaches TIMEOUT-1 with no tx_done -> tx_abort=1 for one cycle, -> IFG. tx_done and timeout in the same cycle: done wins, no abort. tx_done outside BUSY ignored.
- IFG: count IFG_CYCLES cycles, then IDLE; IFG_CYCLES=0 goes BUSY->IDLE directly. tx_sel_hi holds through BUSY and clears entering IFG.
- Pops never fire while the matching avail=0. hi_pop and lo_pop are never high together. Avail/len changes outside IDLE are ignored.

Test Plan:
1. hi_avail=1, len=0x200, tx_done 1024 cycles after start -> tx_start, hi_pop 1 cycle; tx_sel_hi=1, tx_len=0x200; busy high until 12 cycles after tx_done.
2. Both queues always avail, len 0x200/0x040, HI_BURST=4 -> grant order H H H H L H H H H L; streak resets after each L.
3. Alternate hi len 0x200 / lo len 0x040, only one queue avail at a time -> every frame granted in arrival order; streak stays 0; no discards.
4. lo len 0x000 then hi len 0x800 -> discard_en pulses with discard_hi=0 then 1; lo_pop then hi_pop; no tx_start.
5. Grant then no tx_done -> tx_abort exactly TIMEOUT cycles after tx_start, then 12 IFG cycles, then next grant; tx_done coincident with timeout -> no abort.
6. Assert reset during BUSY -> all outputs 0 immediately; after release with hi_avail=1 -> fresh GRANT, tx_start 1 cycle after first sampled edge.

Source files
------------

// File: rtl/xmit_priority_scheduler.sv
// Transmit-path frame arbiter: strict hi/lo priority with a starvation guard,
// length screening, start/done sequencing with timeout abort and inter-frame gap.
module xmit_priority_scheduler #(
    parameter int LEN_W      = 12,
    parameter int MIN_LEN    = 1,
    parameter int MAX_LEN    = 1518,
    parameter int HI_BURST   = 4,
    parameter int IFG_CYCLES = 12,
    parameter int TIMEOUT    = 4096
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             hi_frame_avail,
    input  logic [LEN_W-1:0] hi_frame_len,
    input  logic             lo_frame_avail,
    input  logic [LEN_W-1:0] lo_frame_len,
    input  logic             tx_ready,
    input  logic             tx_done,
    output logic             hi_pop,
    output logic             lo_pop,
    output logic             tx_start,
    output logic             tx_sel_hi,
    output logic [LEN_W-1:0] tx_len,
    output logic             tx_abort,
    output logic             discard_en,
    output logic             discard_hi,
    output logic             busy
);
    localparam int                  STREAK_W   = $clog2(HI_BURST + 2);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(HI_BURST);
    localparam logic [LEN_W-1:0]    LEN_MIN    = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0]    LEN_MAX    = LEN_W'(MAX_LEN);
    // Abort is registered, so it is decided one cycle before the counter would hit TIMEOUT-1.
    localparam logic [15:0]         TMO_LAST   = 16'(TIMEOUT - 2);
    localparam logic [15:0]         IFG_LAST   = 16'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_DISCARD,
        S_BUSY,
        S_IFG
    } state_t;

    state_t              state, state_d;
    logic [15:0]         cnt, cnt_d;
    logic [STREAK_W-1:0] streak, streak_d;
    logic [LEN_W-1:0]    tx_len_d;
    logic                tx_sel_hi_d, hi_pop_d, lo_pop_d, tx_start_d;
    logic                tx_abort_d, discard_en_d, discard_hi_d, busy_d;
    logic                pick_hi, pick_lo, arb_req;
    logic [LEN_W-1:0]    sel_len;

    function automatic logic len_in_range(input logic [LEN_W-1:0] len);
        return (len >= LEN_MIN) && (len <= LEN_MAX);
    endfunction

    function automatic logic [STREAK_W-1:0] streak_sat_inc(input logic [STREAK_W-1:0] s);
        return (s >= STREAK_MAX) ? STREAK_MAX : s + 1'b1;
    endfunction

    assign arb_req = tx_ready & (hi_frame_avail | lo_frame_avail);
    assign pick_hi = hi_frame_avail & ~(lo_frame_avail & (streak == STREAK_MAX));
    assign pick_lo = lo_frame_avail & ~pick_hi;
    assign sel_len = pick_hi ? hi_frame_len : lo_frame_len;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        streak_d     = streak;
        tx_len_d     = tx_len;
        tx_sel_hi_d  = tx_sel_hi;
        hi_pop_d     = 1'b0;
        lo_pop_d     = 1'b0;
        tx_start_d   = 1'b0;
        tx_abort_d   = 1'b0;
        discard_en_d = 1'b0;
        discard_hi_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_req) begin
                    hi_pop_d = pick_hi;
                    lo_pop_d = pick_lo;
                    if (!len_in_range(sel_len)) begin
                        state_d      = S_DISCARD;
                        discard_en_d = 1'b1;
                        discard_hi_d = pick_hi;
                    end else begin
                        state_d     = S_GRANT;
                        tx_start_d  = 1'b1;
                        tx_len_d    = sel_len;
                        tx_sel_hi_d = pick_hi;
                        if (pick_lo || !lo_frame_avail) begin
                            streak_d = '0;
                        end else begin
                            streak_d = streak_sat_inc(streak);
                        end
                    end
                end
            end
            S_GRANT: begin
                state_d = S_BUSY;
                cnt_d   = '0;
            end
            S_DISCARD: state_d = S_IDLE;
            S_BUSY: begin
                if (tx_done || (cnt == TMO_LAST)) begin
                    tx_abort_d  = ~tx_done;
                    tx_sel_hi_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_GRANT) || (state_d == S_BUSY) || (state_d == S_IFG);
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            streak     <= '0;
            tx_len     <= '0;
            tx_sel_hi  <= 1'b0;
            hi_pop     <= 1'b0;
            lo_pop     <= 1'b0;
            tx_start   <= 1'b0;
            tx_abort   <= 1'b0;
            discard_en <= 1'b0;
            discard_hi <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            streak     <= streak_d;
            tx_len     <= tx_len_d;
            tx_sel_hi  <= tx_sel_hi_d;
            hi_pop     <= hi_pop_d;
            lo_pop     <= lo_pop_d;
            tx_start   <= tx_start_d;
            tx_abort   <= tx_abort_d;
            discard_en <= discard_en_d;
            discard_hi <= discard_hi_d;
            busy       <= busy_d;
        end
    end
endmodule
